// File: rtl/opb_regbank_pkg.sv
// ----------------------------------------------------------------------------
// opb_regbank_pkg
//
// Shared types and helpers for the OPB register bank.
//   opb_state_e : transfer state machine encoding (IDLE, DECODE, ACK, HOLD)
//   be_mask     : expands the four OPB byte enables into a 32-bit write mask
//   bitrev32    : moves a word between OPB [0:31] and fabric [31:0] numbering
// ----------------------------------------------------------------------------
package opb_regbank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_ACK    = 2'd2,
      ST_HOLD   = 2'd3
   } opb_state_e;

   // OPB numbers bytes MSB-first, so BE[0] covers the top byte (31:24).
   function automatic logic [31:0] be_mask(input logic [0:3] be);
      return {{8{be[0]}}, {8{be[1]}}, {8{be[2]}}, {8{be[3]}}};
   endfunction

   // OPB bit k is the MSB-relative bit, i.e. fabric bit 31-k. The numeric
   // value of the word does not change; only the index numbering does.
   function automatic logic [31:0] bitrev32(input logic [0:31] d);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < 32; k++) begin
         r[31-k] = d[k];
      end
      return r;
   endfunction

endpackage

// File: rtl/opb_regbank_decode.sv
// ----------------------------------------------------------------------------
// opb_regbank_decode
//
// Purely combinational address decode for the register bank. The parent
// registers the results when it captures a transfer.
//   addr     : OPB address (bit 0 is the MSB)
//   select   : OPB_select
//   hit      : select asserted and address inside [C_BASEADDR, C_HIGHADDR]
//   idx      : word index of the address within the window (low bits)
//   in_range : address inside the window and index below C_NUM_REGS
// ----------------------------------------------------------------------------
module opb_regbank_decode #(
   parameter int                       C_OPB_AWIDTH = 32,
   parameter logic [C_OPB_AWIDTH-1:0]  C_BASEADDR   = 32'h0100_3400,
   parameter logic [C_OPB_AWIDTH-1:0]  C_HIGHADDR   = 32'h0100_34FF,
   parameter int                       C_NUM_REGS   = 8,
   parameter int                       IDX_W        = 3
) (
   input  logic [0:C_OPB_AWIDTH-1] addr,
   input  logic                    select,
   output logic                    hit,
   output logic [IDX_W-1:0]        idx,
   output logic                    in_range
);

   logic                    in_window;
   logic [C_OPB_AWIDTH-1:0] word;

   // The byte offset is shifted down to a word index, which discards the two
   // low address bits so sub-word addresses alias onto their register.
   assign in_window = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
   assign word      = (addr - C_BASEADDR) >> 2;
   assign hit       = select && in_window;
   assign idx       = word[IDX_W-1:0];
   assign in_range  = in_window && (word < C_OPB_AWIDTH'(C_NUM_REGS));

endmodule

// File: rtl/opb_register_bank.sv
// ----------------------------------------------------------------------------
// opb_register_bank
//
// OPB slave exposing C_NUM_REGS 32-bit software registers with byte-enable
// writes, per-register write strobes, optional self-clearing registers and
// optional read-only status registers fed from fabric.
//
// Ports
//   OPB_Clk, OPB_Rst_n  : clock and synchronous active-low reset
//   OPB_ABus/BE/DBus    : address, byte enables, write data (bit 0 = MSB)
//   OPB_RNW             : 1 = read, 0 = write
//   OPB_select          : transfer request
//   OPB_seqAddr         : burst hint, continues a transfer from HOLD
//   Sl_DBus             : read data, non-zero only during a read ack
//   Sl_errAck, Sl_retry : tied low
//   Sl_toutSup          : timeout suppress while a transfer is in progress
//   Sl_xferAck          : one-cycle transfer acknowledge
//   user_data_out       : register i on bits [32i+31:32i]
//   user_data_in        : status words for read-only registers
//   user_we             : one-cycle strobe, aligned with the new register value
// ----------------------------------------------------------------------------
module opb_register_bank
   import opb_regbank_pkg::*;
#(
   parameter logic [31:0]            C_BASEADDR     = 32'h0100_3400,
   parameter logic [31:0]            C_HIGHADDR     = 32'h0100_34FF,
   parameter int                     C_NUM_REGS     = 8,
   parameter int                     C_OPB_AWIDTH   = 32,
   parameter int                     C_OPB_DWIDTH   = 32,
   parameter logic [C_NUM_REGS-1:0]  C_RO_MASK      = {C_NUM_REGS{1'b0}},
   parameter logic [C_NUM_REGS-1:0]  C_SELFCLR_MASK = {C_NUM_REGS{1'b0}},
   parameter logic [31:0]            C_RESET_VAL    = 32'h0
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
   input  logic [0:3]                OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup,
   output logic                      Sl_xferAck,
   output logic [32*C_NUM_REGS-1:0]  user_data_out,
   input  logic [32*C_NUM_REGS-1:0]  user_data_in,
   output logic [C_NUM_REGS-1:0]     user_we
);

   localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

   opb_state_e       state;

   logic             dec_hit;
   logic             dec_in_range;
   logic [IDX_W-1:0] dec_idx;

   logic             lat_rnw;
   logic             lat_in_range;
   logic [IDX_W-1:0] lat_idx;
   logic [31:0]      lat_data;
   logic [31:0]      lat_mask;

   logic [31:0]      regs_q [C_NUM_REGS];
   logic [31:0]      rd_mux;
   logic             capture;
   logic             wr_commit;

   assign Sl_errAck = 1'b0;
   assign Sl_retry  = 1'b0;

   opb_regbank_decode #(
      .C_OPB_AWIDTH (C_OPB_AWIDTH),
      .C_BASEADDR   (C_BASEADDR),
      .C_HIGHADDR   (C_HIGHADDR),
      .C_NUM_REGS   (C_NUM_REGS),
      .IDX_W        (IDX_W)
   ) u_decode (
      .addr     (OPB_ABus),
      .select   (OPB_select),
      .hit      (dec_hit),
      .idx      (dec_idx),
      .in_range (dec_in_range)
   );

   // A transfer is captured either from IDLE on a window hit or from HOLD
   // when the master continues a burst. The burst path does not re-check the
   // window; an address outside it simply decodes as out of range.
   assign capture = ((state == ST_IDLE) && dec_hit) ||
                    ((state == ST_HOLD) && OPB_select && OPB_seqAddr);

   // Writes land at the end of the ACK cycle and only on writable, existing
   // registers; everything else is acknowledged and dropped.
   assign wr_commit = (state == ST_ACK) && !lat_rnw && lat_in_range &&
                      !C_RO_MASK[lat_idx];

   // Read data source for the captured index: fabric status for read-only
   // registers, the stored value otherwise, zero beyond the last register.
   always_comb begin
      rd_mux = '0;
      if (lat_in_range) begin
         if (C_RO_MASK[lat_idx]) begin
            rd_mux = user_data_in[32*lat_idx +: 32];
         end else begin
            rd_mux = regs_q[lat_idx];
         end
      end
   end

   // Transfer state machine. Every Sl_* output is a flop so nothing on the
   // OPB input side reaches the slave outputs combinationally. Sl_DBus is
   // loaded only on the DECODE->ACK edge of a read and cleared right after.
   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst_n) begin
         state        <= ST_IDLE;
         Sl_xferAck   <= 1'b0;
         Sl_toutSup   <= 1'b0;
         Sl_DBus      <= '0;
         lat_rnw      <= 1'b0;
         lat_in_range <= 1'b0;
         lat_idx      <= '0;
         lat_data     <= '0;
         lat_mask     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (capture) begin
                  state      <= ST_DECODE;
                  Sl_toutSup <= 1'b1;
               end
            end
            ST_DECODE: begin
               state      <= ST_ACK;
               Sl_xferAck <= 1'b1;
               Sl_DBus    <= lat_rnw ? bitrev32(rd_mux) : '0;
            end
            ST_ACK: begin
               state      <= ST_HOLD;
               Sl_xferAck <= 1'b0;
               Sl_toutSup <= 1'b0;
               Sl_DBus    <= '0;
            end
            ST_HOLD: begin
               if (!OPB_select) begin
                  state <= ST_IDLE;
               end else if (OPB_seqAddr) begin
                  state      <= ST_DECODE;
                  Sl_toutSup <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (capture) begin
            lat_rnw      <= OPB_RNW;
            lat_idx      <= dec_idx;
            lat_in_range <= dec_in_range;
            lat_data     <= bitrev32(OPB_DBus);
            lat_mask     <= be_mask(OPB_BE);
         end
      end
   end

   // Register storage and write strobes. The strobe is raised on the same
   // edge that commits the data, so both appear together one cycle after
   // ACK. A self-clearing register uses its own strobe to know the written
   // value has been visible for a cycle; a fresh commit takes priority over
   // that clear. Read-only slots hold the reset value since they store nothing.
   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst_n) begin
         for (int i = 0; i < C_NUM_REGS; i++) begin
            regs_q[i] <= C_RESET_VAL;
         end
         user_we <= '0;
      end else begin
         for (int i = 0; i < C_NUM_REGS; i++) begin
            user_we[i] <= wr_commit && (lat_idx == IDX_W'(i));
            if (C_RO_MASK[i]) begin
               regs_q[i] <= C_RESET_VAL;
            end else if (wr_commit && (lat_idx == IDX_W'(i))) begin
               regs_q[i] <= (regs_q[i] & ~lat_mask) | (lat_data & lat_mask);
            end else if (C_SELFCLR_MASK[i] && user_we[i]) begin
               regs_q[i] <= C_RESET_VAL;
            end
         end
      end
   end

   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
      assign user_data_out[32*g +: 32] = regs_q[g];
   end

endmodule

// File: tb/tb_opb_register_bank.sv
// ----------------------------------------------------------------------------
// tb_opb_register_bank
//
// Directed testbench for opb_register_bank with eight registers, register 1
// self-clearing and register 7 read-only. Each test task drives its own
// transfers and compares against hand-computed values.
// ----------------------------------------------------------------------------
module tb_opb_register_bank;

   logic          OPB_Clk = 1'b0;
   logic          OPB_Rst_n;
   logic [0:31]   OPB_ABus;
   logic [0:3]    OPB_BE;
   logic [0:31]   OPB_DBus;
   logic          OPB_RNW;
   logic          OPB_select;
   logic          OPB_seqAddr;
   logic [0:31]   Sl_DBus;
   logic          Sl_errAck;
   logic          Sl_retry;
   logic          Sl_toutSup;
   logic          Sl_xferAck;
   logic [255:0]  user_data_out;
   logic [255:0]  user_data_in;
   logic [7:0]    user_we;

   int            checks   = 0;
   int            failures = 0;

   // Results captured by xfer, relative to the cycle select was raised.
   int            ack_cyc;
   logic          tout_c1;
   logic [31:0]   dbus_c1;
   logic [31:0]   dbus_ack;
   logic [31:0]   dbus_c3;
   logic [7:0]    we_c3;
   logic [7:0]    we_c4;
   logic [255:0]  udo_c3;
   logic [255:0]  udo_c4;

   always #5 OPB_Clk = ~OPB_Clk;

   opb_register_bank #(
      .C_BASEADDR     (32'h0100_3400),
      .C_HIGHADDR     (32'h0100_34FF),
      .C_NUM_REGS     (8),
      .C_OPB_AWIDTH   (32),
      .C_OPB_DWIDTH   (32),
      .C_RO_MASK      (8'b1000_0000),
      .C_SELFCLR_MASK (8'b0000_0010),
      .C_RESET_VAL    (32'h0)
   ) dut (
      .OPB_Clk       (OPB_Clk),
      .OPB_Rst_n     (OPB_Rst_n),
      .OPB_ABus      (OPB_ABus),
      .OPB_BE        (OPB_BE),
      .OPB_DBus      (OPB_DBus),
      .OPB_RNW       (OPB_RNW),
      .OPB_select    (OPB_select),
      .OPB_seqAddr   (OPB_seqAddr),
      .Sl_DBus       (Sl_DBus),
      .Sl_errAck     (Sl_errAck),
      .Sl_retry      (Sl_retry),
      .Sl_toutSup    (Sl_toutSup),
      .Sl_xferAck    (Sl_xferAck),
      .user_data_out (user_data_out),
      .user_data_in  (user_data_in),
      .user_we       (user_we)
   );

   // Single transfer: select is raised on a falling edge, so the next rising
   // edge is edge 0 and negedge sample c lies in cycle c. Select drops right
   // after the ack is seen; the two following cycles are recorded.
   task automatic xfer(input logic rnw, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
      @(negedge OPB_Clk);
      OPB_select  = 1'b1;
      OPB_seqAddr = 1'b0;
      OPB_RNW     = rnw;
      OPB_ABus    = addr;
      OPB_BE      = be;
      OPB_DBus    = data;
      ack_cyc     = -1;
      dbus_ack    = 32'h0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge OPB_Clk);
         if (c == 1) begin
            tout_c1 = Sl_toutSup;
            dbus_c1 = Sl_DBus;
         end
         if (Sl_xferAck) begin
            ack_cyc  = c;
            dbus_ack = Sl_DBus;
            break;
         end
      end
      OPB_select = 1'b0;
      @(negedge OPB_Clk);
      dbus_c3 = Sl_DBus;
      we_c3   = user_we;
      udo_c3  = user_data_out;
      @(negedge OPB_Clk);
      we_c4   = user_we;
      udo_c4  = user_data_out;
   endtask

   task automatic test_reset;
      OPB_Rst_n    = 1'b0;
      OPB_select   = 1'b0;
      OPB_seqAddr  = 1'b0;
      OPB_RNW      = 1'b0;
      OPB_ABus     = 32'h0;
      OPB_BE       = 4'h0;
      OPB_DBus     = 32'h0;
      user_data_in = '0;
      repeat (3) @(posedge OPB_Clk);
      @(negedge OPB_Clk);
      checks++;
      if (Sl_xferAck !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_xferAck: got %b want 0", Sl_xferAck);
      end
      checks++;
      if (Sl_toutSup !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_toutSup: got %b want 0", Sl_toutSup);
      end
      checks++;
      if (Sl_DBus !== 32'h0) begin
         failures++;
         $display("[TB] FAIL reset_DBus: got %h want 00000000", Sl_DBus);
      end
      checks++;
      if (user_we !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_user_we: got %h want 00", user_we);
      end
      checks++;
      if (user_data_out !== 256'h0) begin
         failures++;
         $display("[TB] FAIL reset_user_data_out: got %h want 0", user_data_out);
      end
      checks++;
      if ({Sl_errAck, Sl_retry} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL reset_err_retry: got %b want 00", {Sl_errAck, Sl_retry});
      end
      OPB_Rst_n = 1'b1;
   endtask

   task automatic test_full_write;
      xfer(1'b0, 32'h0100_340C, 4'b1111, 32'hDEAD_BEEF);
      checks++;
      if (ack_cyc !== 2) begin
         failures++;
         $display("[TB] FAIL wr3_ack_cycle: got %0d want 2", ack_cyc);
      end
      checks++;
      if (tout_c1 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL wr3_toutSup_c1: got %b want 1", tout_c1);
      end
      checks++;
      if (dbus_ack !== 32'h0) begin
         failures++;
         $display("[TB] FAIL wr3_dbus_on_write: got %h want 00000000", dbus_ack);
      end
      checks++;
      if (udo_c3[127:96] !== 32'hDEAD_BEEF) begin
         failures++;
         $display("[TB] FAIL wr3_data_c3: got %h want deadbeef", udo_c3[127:96]);
      end
      checks++;
      if (we_c3 !== 8'b0000_1000) begin
         failures++;
         $display("[TB] FAIL wr3_we_c3: got %b want 00001000", we_c3);
      end
      checks++;
      if (we_c4 !== 8'h00) begin
         failures++;
         $display("[TB] FAIL wr3_we_c4: got %b want 00000000", we_c4);
      end
      checks++;
      if (udo_c4[127:96] !== 32'hDEAD_BEEF) begin
         failures++;
         $display("[TB] FAIL wr3_data_c4: got %h want deadbeef", udo_c4[127:96]);
      end
   endtask

   task automatic test_byte_enable;
      xfer(1'b0, 32'h0100_3400, 4'b0100, 32'h1122_3344);
      checks++;
      if (udo_c3[31:0] !== 32'h0022_0000) begin
         failures++;
         $display("[TB] FAIL be0100_reg0: got %h want 00220000", udo_c3[31:0]);
      end
      xfer(1'b1, 32'h0100_3400, 4'b1111, 32'h0);
      checks++;
      if (ack_cyc !== 2) begin
         failures++;
         $display("[TB] FAIL rd0_ack_cycle: got %0d want 2", ack_cyc);
      end
      checks++;
      if (dbus_ack !== 32'h0022_0000) begin
         failures++;
         $display("[TB] FAIL rd0_dbus_ack: got %h want 00220000", dbus_ack);
      end
      checks++;
      if (dbus_c1 !== 32'h0) begin
         failures++;
         $display("[TB] FAIL rd0_dbus_before_ack: got %h want 00000000", dbus_c1);
      end
      checks++;
      if (dbus_c3 !== 32'h0) begin
         failures++;
         $display("[TB] FAIL rd0_dbus_after_ack: got %h want 00000000", dbus_c3);
      end
      checks++;
      if (we_c3 !== 8'h00) begin
         failures++;
         $display("[TB] FAIL rd0_no_we: got %b want 00000000", we_c3);
      end
      // No byte enables: still strobed, contents untouched.
      xfer(1'b0, 32'h0100_3400, 4'b0000, 32'hFFFF_FFFF);
      checks++;
      if (we_c3 !== 8'b0000_0001) begin
         failures++;
         $display("[TB] FAIL be0000_we: got %b want 00000001", we_c3);
      end
      checks++;
      if (udo_c3[31:0] !== 32'h0022_0000) begin
         failures++;
         $display("[TB] FAIL be0000_reg0: got %h want 00220000", udo_c3[31:0]);
      end
   endtask

   task automatic test_self_clear;
      xfer(1'b0, 32'h0100_3404, 4'b1111, 32'h0000_0001);
      checks++;
      if (udo_c3[63:32] !== 32'h1) begin
         failures++;
         $display("[TB] FAIL selfclr_c3: got %h want 00000001", udo_c3[63:32]);
      end
      checks++;
      if (we_c3 !== 8'b0000_0010) begin
         failures++;
         $display("[TB] FAIL selfclr_we: got %b want 00000010", we_c3);
      end
      checks++;
      if (udo_c4[63:32] !== 32'h0) begin
         failures++;
         $display("[TB] FAIL selfclr_c4: got %h want 00000000", udo_c4[63:32]);
      end
   endtask

   // Two-beat burst to the self-clearing register: acks in cycles 2 and 5,
   // each written value visible for exactly one cycle (3 and 6).
   task automatic test_back_to_back;
      logic [31:0] exp_reg [1:7];
      logic        exp_ack [1:7];
      exp_reg = '{32'h0, 32'h0, 32'hA5A5_0001, 32'h0, 32'h0, 32'h5A5A_0002, 32'h0};
      exp_ack = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      @(negedge OPB_Clk);
      OPB_select  = 1'b1;
      OPB_seqAddr = 1'b1;
      OPB_RNW     = 1'b0;
      OPB_ABus    = 32'h0100_3404;
      OPB_BE      = 4'b1111;
      OPB_DBus    = 32'hA5A5_0001;
      for (int c = 1; c <= 7; c++) begin
         @(negedge OPB_Clk);
         checks++;
         if (user_data_out[63:32] !== exp_reg[c]) begin
            failures++;
            $display("[TB] FAIL burst_reg1_c%0d: got %h want %h", c, user_data_out[63:32], exp_reg[c]);
         end
         checks++;
         if (Sl_xferAck !== exp_ack[c]) begin
            failures++;
            $display("[TB] FAIL burst_ack_c%0d: got %b want %b", c, Sl_xferAck, exp_ack[c]);
         end
         if (c == 2) OPB_DBus = 32'h5A5A_0002;
         if (c == 5) begin
            OPB_select  = 1'b0;
            OPB_seqAddr = 1'b0;
         end
      end
   endtask

   task automatic test_read_only;
      logic [255:0] exp_udo;
      user_data_in[255:224] = 32'hCAFE_F00D;
      user_data_in[127:96]  = 32'hBAAD_BAAD;
      xfer(1'b1, 32'h0100_341C, 4'b1111, 32'h0);
      checks++;
      if (dbus_ack !== 32'hCAFE_F00D) begin
         failures++;
         $display("[TB] FAIL ro7_read: got %h want cafef00d", dbus_ack);
      end
      xfer(1'b0, 32'h0100_341C, 4'b1111, 32'h1234_5678);
      checks++;
      if (ack_cyc !== 2) begin
         failures++;
         $display("[TB] FAIL ro7_write_ack: got %0d want 2", ack_cyc);
      end
      checks++;
      if (we_c3 !== 8'h00) begin
         failures++;
         $display("[TB] FAIL ro7_write_we: got %b want 00000000", we_c3);
      end
      checks++;
      if (udo_c3[255:224] !== 32'h0) begin
         failures++;
         $display("[TB] FAIL ro7_write_data: got %h want 00000000", udo_c3[255:224]);
      end
      // Low address bits are ignored; a writable register ignores its status input.
      xfer(1'b1, 32'h0100_340F, 4'b1111, 32'h0);
      checks++;
      if (dbus_ack !== 32'hDEAD_BEEF) begin
         failures++;
         $display("[TB] FAIL rd3_unaligned: got %h want deadbeef", dbus_ack);
      end
      xfer(1'b1, 32'h0100_3420, 4'b1111, 32'h0);
      checks++;
      if (ack_cyc !== 2) begin
         failures++;
         $display("[TB] FAIL idx8_read_ack: got %0d want 2", ack_cyc);
      end
      checks++;
      if (dbus_ack !== 32'h0) begin
         failures++;
         $display("[TB] FAIL idx8_read_data: got %h want 00000000", dbus_ack);
      end
      exp_udo          = '0;
      exp_udo[31:0]    = 32'h0022_0000;
      exp_udo[127:96]  = 32'hDEAD_BEEF;
      xfer(1'b0, 32'h0100_34FC, 4'b1111, 32'hFFFF_FFFF);
      checks++;
      if (ack_cyc !== 2) begin
         failures++;
         $display("[TB] FAIL idx63_write_ack: got %0d want 2", ack_cyc);
      end
      checks++;
      if (we_c3 !== 8'h00) begin
         failures++;
         $display("[TB] FAIL idx63_write_we: got %b want 00000000", we_c3);
      end
      checks++;
      if (udo_c3 !== exp_udo) begin
         failures++;
         $display("[TB] FAIL idx63_write_regs: got %h want %h", udo_c3, exp_udo);
      end
   endtask

   task automatic test_out_of_window;
      logic [31:0] addrs [2];
      int          acks;
      int          touts;
      addrs = '{32'h0100_33FC, 32'h0100_3500};
      for (int a = 0; a < 2; a++) begin
         @(negedge OPB_Clk);
         OPB_select = 1'b1;
         OPB_RNW    = 1'b1;
         OPB_ABus   = addrs[a];
         acks       = 0;
         touts      = 0;
         for (int c = 1; c <= 6; c++) begin
            @(negedge OPB_Clk);
            if (Sl_xferAck) acks++;
            if (Sl_toutSup) touts++;
         end
         OPB_select = 1'b0;
         checks++;
         if ((acks !== 0) || (touts !== 0)) begin
            failures++;
            $display("[TB] FAIL outside_%h: acks=%0d touts=%0d want 0/0", addrs[a], acks, touts);
         end
      end
   endtask

   // Reset lands on the DECODE edge of a write; with select still high the
   // transfer restarts after release and acks two cycles later.
   task automatic test_reset_midflight;
      int acks;
      int first_ack;
      acks      = 0;
      first_ack = -1;
      @(negedge OPB_Clk);
      OPB_select  = 1'b1;
      OPB_seqAddr = 1'b0;
      OPB_RNW     = 1'b0;
      OPB_ABus    = 32'h0100_3408;
      OPB_BE      = 4'b1111;
      OPB_DBus    = 32'h55AA_55AA;
      for (int c = 1; c <= 8; c++) begin
         @(negedge OPB_Clk);
         if (Sl_xferAck) begin
            acks++;
            if (first_ack < 0) first_ack = c;
         end
         if (c == 1) begin
            OPB_Rst_n = 1'b0;
         end
         if (c == 2) begin
            checks++;
            if ({Sl_xferAck, Sl_toutSup, Sl_errAck, Sl_retry} !== 4'b0000 || Sl_DBus !== 32'h0) begin
               failures++;
               $display("[TB] FAIL rstmid_sl_outputs: got ack=%b tout=%b dbus=%h want all 0",
                        Sl_xferAck, Sl_toutSup, Sl_DBus);
            end
            checks++;
            if (user_data_out !== 256'h0 || user_we !== 8'h00) begin
               failures++;
               $display("[TB] FAIL rstmid_regs: got %h we=%b want 0", user_data_out, user_we);
            end
            OPB_Rst_n = 1'b1;
         end
         if (c == 3) begin
            checks++;
            if (Sl_toutSup !== 1'b1) begin
               failures++;
               $display("[TB] FAIL rstmid_restart_tout: got %b want 1", Sl_toutSup);
            end
         end
         if (c == 4) OPB_select = 1'b0;
         if (c == 5) begin
            checks++;
            if (user_data_out[95:64] !== 32'h55AA_55AA) begin
               failures++;
               $display("[TB] FAIL rstmid_reg2: got %h want 55aa55aa", user_data_out[95:64]);
            end
            checks++;
            if (user_we !== 8'b0000_0100) begin
               failures++;
               $display("[TB] FAIL rstmid_we: got %b want 00000100", user_we);
            end
         end
      end
      checks++;
      if (first_ack !== 4 || acks !== 1) begin
         failures++;
         $display("[TB] FAIL rstmid_ack: first=%0d count=%0d want 4/1", first_ack, acks);
      end
   endtask

   initial begin
      test_reset();
      test_full_write();
      test_byte_enable();
      test_self_clear();
      test_back_to_back();
      test_read_only();
      test_out_of_window();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
